rv32i_dmem_ctrl: RTL and testbench

Memory-stage data-memory controller for the pipelined RV32I core. It accepts load/store requests from the M stage, described by memory_transaction, mem_write, width_type and an address. It sequences each request onto a single-outstanding req/gnt/rvalid data bus and stalls the pipeline until the transaction completes. Store data is lane-aligned with byte enables; load data is extracted and sign- or zero-extended before writeback.

---
 rtl/rv32i_dmem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_rv32i_dmem_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_ctrl.sv
// rv32i_dmem_ctrl: M-stage load/store sequencer onto a req/gnt/rvalid bus.
// Optional WAIT watchdog with bus_error pulse: define DMEM_CTRL_TIMEOUT_EN.
module rv32i_dmem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_txn_M,
  input  logic                  mem_write_M,
  input  logic [2:0]            width_type_M,
  input  logic [ADDR_WIDTH-1:0] addr_M,
  input  logic [DATA_WIDTH-1:0] wdata_M,
  input  logic                  flush_M,
  output logic                  stall_M,
  output logic [DATA_WIDTH-1:0] load_data_M,
  output logic                  load_valid_M,
  output logic                  misaligned_M,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_error
);

  // width_type[1:0] selects size, width_type[2] marks unsigned loads
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            wt_q, wt_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] ldata_q, ldata_d;
  logic                  lvalid_q, lvalid_d;

  logic                  is_byte, is_half, is_word;
  logic                  mis, accept, rsp;
  logic [3:0]            be_new;
  logic [DATA_WIDTH-1:0] wdata_new;
  logic [DATA_WIDTH-1:0] rsh, ext;

`ifdef DMEM_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Decode the incoming M-stage request: alignment, lanes, store data
  always_comb begin
    is_byte   = (width_type_M[1:0] == SZ_BYTE);
    is_half   = (width_type_M[1:0] == SZ_HALF);
    is_word   = !is_byte && !is_half;
    mis       = (is_half && addr_M[0]) ||
                (is_word && (addr_M[1:0] != 2'b00));
    accept    = (state_q == S_IDLE) && mem_txn_M &&
                !mis && !flush_M;
    be_new    = 4'b1111;
    wdata_new = wdata_M;
    if (is_byte) begin
      be_new    = 4'b0001 << addr_M[1:0];
      wdata_new = {4{wdata_M[7:0]}};
    end else if (is_half) begin
      be_new    = 4'b0011 << addr_M[1:0];
      wdata_new = {2{wdata_M[15:0]}};
    end
  end

  // Pull the addressed lane down to bit 0 and extend it
  always_comb begin
    rsh = bus_rdata >> {off_q, 3'b000};
    ext = rsh;
    if (wt_q[1:0] == SZ_BYTE) begin
      ext = {{24{rsh[7] & ~wt_q[2]}}, rsh[7:0]};
    end else if (wt_q[1:0] == SZ_HALF) begin
      ext = {{16{rsh[15] & ~wt_q[2]}}, rsh[15:0]};
    end
  end

  // Next-state logic and request/response bookkeeping
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    wt_d     = wt_q;
    kill_d   = kill_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    rsp      = 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          addr_d  = {addr_M[ADDR_WIDTH-1:2], 2'b00};
          we_d    = mem_write_M;
          be_d    = be_new;
          wdata_d = wdata_new;
          off_d   = addr_M[1:0];
          wt_d    = width_type_M;
          kill_d  = 1'b0;
        end
      end
      S_REQ: begin
        kill_d = kill_q | flush_M;
        if (bus_gnt) begin
          if (bus_rvalid) rsp = 1'b1;
          else state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        kill_d = kill_q | flush_M;
        if (bus_rvalid) begin
          rsp = 1'b1;
        end
`ifdef DMEM_CTRL_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (rsp) begin
      state_d = S_DONE;
      if (!we_q && !kill_d) begin
        ldata_d  = ext;
        lvalid_d = 1'b1;
      end
    end
  end

  // State and bus/response registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      wt_q     <= '0;
      kill_q   <= 1'b0;
      ldata_q  <= '0;
      lvalid_q <= 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      wt_q     <= wt_d;
      kill_q   <= kill_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
`ifdef DMEM_CTRL_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign stall_M      = accept || (state_q == S_REQ) ||
                        (state_q == S_WAIT);
  assign misaligned_M = (state_q == S_IDLE) && mem_txn_M && mis;
  assign bus_req      = (state_q == S_REQ);
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_be       = be_q;
  assign load_data_M  = ldata_q;
  assign load_valid_M = lvalid_q;

`ifdef DMEM_CTRL_TIMEOUT_EN
  assign bus_error = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// tb_rv32i_dmem_ctrl: directed vectors with scoreboard queues for
// bus handshakes and load writebacks.
module tb_rv32i_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_txn_M, mem_write_M, flush_M;
  logic [2:0]  width_type_M;
  logic [31:0] addr_M, wdata_M;
  logic        stall_M, load_valid_M, misaligned_M;
  logic [31:0] load_data_M;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_error;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  always #5 clk = ~clk;

  rv32i_dmem_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_txn_M(mem_txn_M),
    .mem_write_M(mem_write_M),
    .width_type_M(width_type_M),
    .addr_M(addr_M),
    .wdata_M(wdata_M),
    .flush_M(flush_M),
    .stall_M(stall_M),
    .load_data_M(load_data_M),
    .load_valid_M(load_valid_M),
    .misaligned_M(misaligned_M),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be(bus_be),
    .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata),
    .bus_error(bus_error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] ld_q[$];
  bus_exp_t    mon_b;
  logic [31:0] mon_l;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
    bus_exp_t e;
    e.addr  = a;
    e.we    = we;
    e.be    = be;
    e.wdata = wd;
    bus_q.push_back(e);
  endtask

  // Monitor: compare every accepted request and every writeback
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (load_valid_M) begin
        if (ld_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_load: got %h expected none",
                   load_data_M);
        end else begin
          mon_l = ld_q.pop_front();
          chk("load_data", load_data_M, mon_l);
        end
      end
      if (bus_req && bus_gnt) begin
        if (bus_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected none",
                   bus_addr);
        end else begin
          mon_b = bus_q.pop_front();
          chk("bus_addr", bus_addr, mon_b.addr);
          chk("bus_we_be", {27'b0, bus_we, bus_be},
              {27'b0, mon_b.we, mon_b.be});
          chk("bus_wdata", bus_wdata, mon_b.wdata);
        end
      end
    end
  end

  // Issue one access and play the bus slave until stall drops
  task automatic txn(input logic we, input logic [2:0] wt,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int gnt_lat,
                     input int rv_lat, input int flush_at,
                     input int exp_stall, input logic exp_err);
    int   n    = 0;
    int   rq   = 0;
    int   wc   = 0;
    logic gr   = 1'b0;
    logic done = 1'b0;
    logic err  = 1'b0;
    @(posedge clk);
    #1;
    mem_txn_M    = 1'b1;
    mem_write_M  = we;
    width_type_M = wt;
    addr_M       = addr;
    wdata_M      = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'hDEAD_DEAD;
      flush_M    = 1'b0;
      if (!stall_M) begin
        done = 1'b1;
        err  = bus_error;
      end else begin
        n++;
        if (bus_req) begin
          rq++;
          if (rq > gnt_lat) begin
            bus_gnt = 1'b1;
            gr      = 1'b1;
            if (rv_lat == 0) begin
              bus_rvalid = 1'b1;
              bus_rdata  = rd;
            end
          end
        end else if (gr) begin
          wc++;
          if (wc == flush_at) flush_M = 1'b1;
          if (wc == rv_lat) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
          end
        end
      end
    end
    chk("txn_done", {31'b0, done}, 32'd1);
    chk("stall_cycles", n, exp_stall);
    chk("bus_error", {31'b0, err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    mem_txn_M   = 1'b0;
    mem_write_M = 1'b0;
  endtask

  task automatic misal(input logic [2:0] wt, input logic [31:0] addr);
    @(posedge clk);
    #1;
    mem_txn_M    = 1'b1;
    mem_write_M  = 1'b0;
    width_type_M = wt;
    addr_M       = addr;
    @(negedge clk);
    chk("misaligned", {31'b0, misaligned_M}, 32'd1);
    chk("mis_stall", {31'b0, stall_M}, 32'd0);
    chk("mis_req", {31'b0, bus_req}, 32'd0);
    @(posedge clk);
    #1;
    mem_txn_M = 1'b0;
    @(negedge clk);
    chk("mis_req_after", {31'b0, bus_req}, 32'd0);
    chk("mis_clear", {31'b0, misaligned_M}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    mem_txn_M    = 1'b0;
    mem_write_M  = 1'b0;
    width_type_M = LW;
    addr_M       = 32'h0;
    wdata_M      = 32'h0;
    flush_M      = 1'b0;
    bus_gnt      = 1'b0;
    bus_rvalid   = 1'b0;
    bus_rdata    = 32'h0;
    @(negedge clk);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_we_be", {27'b0, bus_we, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_ldata", load_data_M, 32'd0);
    chk("rst_lvalid_err_stall",
        {29'b0, load_valid_M, bus_error, stall_M}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_bus(32'h1000, 1'b0, 4'b1000, 32'h0);
    ld_q.push_back(32'hFFFF_FF80);
    txn(1'b0, LB, 32'h1003, 32'h0, 32'h8000_0000, 0, 0, 0, 2, 1'b0);

    push_bus(32'h2000, 1'b0, 4'b1100, 32'h0);
    ld_q.push_back(32'h0000_BEEF);
    txn(1'b0, LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 0, 3, 0, 5, 1'b0);

    push_bus(32'h10, 1'b1, 4'b0001, 32'hA5A5_A5A5);
    txn(1'b1, LB, 32'h10, 32'h0000_00A5, 32'h0, 0, 0, 0, 2, 1'b0);

    push_bus(32'h10, 1'b1, 4'b0100, 32'hA5A5_A5A5);
    txn(1'b1, LB, 32'h12, 32'h0000_00A5, 32'h0, 0, 1, 0, 3, 1'b0);

    push_bus(32'h14, 1'b1, 4'b1100, 32'hABCD_ABCD);
    txn(1'b1, LH, 32'h16, 32'h1234_ABCD, 32'h0, 1, 0, 0, 3, 1'b0);

    push_bus(32'h20, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    txn(1'b1, LW, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 4, 1'b0);

    push_bus(32'h30, 1'b0, 4'b0011, 32'h0);
    ld_q.push_back(32'hFFFF_8001);
    txn(1'b0, LH, 32'h30, 32'h0, 32'h0000_8001, 0, 0, 0, 2, 1'b0);

    push_bus(32'h40, 1'b0, 4'b0010, 32'h0);
    ld_q.push_back(32'h0000_00F7);
    txn(1'b0, LBU, 32'h41, 32'h0, 32'h0000_F700, 2, 0, 0, 4, 1'b0);

    push_bus(32'h50, 1'b0, 4'b1111, 32'h0);
    ld_q.push_back(32'h1357_9BDF);
    txn(1'b0, LW, 32'h50, 32'h0, 32'h1357_9BDF, 0, 1, 0, 3, 1'b0);

    push_bus(32'h60, 1'b0, 4'b0100, 32'h0);
    ld_q.push_back(32'h0000_007F);
    txn(1'b0, LB, 32'h62, 32'h0, 32'h007F_0000, 0, 0, 0, 2, 1'b0);

    misal(LW, 32'h102);
    misal(LH, 32'h103);
    misal(LHU, 32'h201);

    push_bus(32'h200, 1'b0, 4'b1111, 32'h0);
    txn(1'b0, LW, 32'h200, 32'h0, 32'h1111_1111, 0, 3, 1, 5, 1'b0);

    push_bus(32'h204, 1'b0, 4'b1111, 32'h0);
    ld_q.push_back(32'hCAFE_F00D);
    txn(1'b0, LW, 32'h204, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 2, 1'b0);

    @(negedge clk);
    bus_gnt    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_5555;
    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    chk("stray_lvalid", {31'b0, load_valid_M}, 32'd0);
    chk("stray_req", {31'b0, bus_req}, 32'd0);

`ifdef DMEM_CTRL_TIMEOUT_EN
    push_bus(32'h300, 1'b0, 4'b1111, 32'h0);
    txn(1'b0, LW, 32'h300, 32'h0, 32'h0, 0, 99, 0, 10, 1'b1);
    @(negedge clk);
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("late_rvalid", {31'b0, load_valid_M}, 32'd0);
`endif

    @(posedge clk);
    #1;
    mem_txn_M    = 1'b1;
    width_type_M = LW;
    addr_M       = 32'h400;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_req_pre", {31'b0, bus_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, bus_req}, 32'd0);
    chk("rst_mid_addr", bus_addr, 32'd0);
    mem_txn_M = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (3) @(posedge clk);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("ld_q_empty", ld_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
